// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the MIPS execute stage.
// mult/multu use radix-2 shift-add, div/divu use restoring division; signed ops work on magnitudes.
module mdu_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic        div0;
  logic [31:0] a_lat;
  logic [31:0] m;
  logic [63:0] acc;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_rem;
  logic [33:0] div_diff;
  logic [63:0] acc_nxt;
  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // op[0]=1 selects the unsigned variant; only signed ops take magnitudes.
  assign abs_a = (~op[0] & a[31]) ? (~a + 32'd1) : a;
  assign abs_b = (~op[0] & b[31]) ? (~b + 32'd1) : b;

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    div_rem  = acc[63:31];
    div_diff = {1'b0, div_rem} - {2'b00, m};
    if (is_div) begin
      if (!div_diff[33]) acc_nxt = {div_diff[31:0], acc[30:0], 1'b1};
      else               acc_nxt = {div_rem[31:0], acc[30:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[31:1]};
    end
  end

  // Sign fix-up: quotient/product take sign(a)^sign(b), remainder takes sign(a).
  always_comb begin
    prod = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
    if (div0) begin
      res_hi = a_lat;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div) begin
      res_hi = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
      res_lo = (neg_a ^ neg_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      div0   <= 1'b0;
      a_lat  <= 32'd0;
      m      <= 32'd0;
      acc    <= 64'd0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_CALC;
            cnt    <= 5'd0;
            is_div <= op[1];
            neg_a  <= ~op[0] & a[31];
            neg_b  <= ~op[0] & b[31];
            div0   <= op[1] & (b == 32'd0);
            a_lat  <= a;
            if (op[1]) begin
              acc <= {32'd0, abs_a};
              m   <= abs_b;
            end else begin
              acc <= {32'd0, abs_b};
              m   <= abs_a;
            end
          end else begin
            if (wr_hi) hi_q <= wdata;
            if (wr_lo) lo_q <= wdata;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, randomized ops against an arithmetic model,
// and hand-written sequences for write priority, ignored starts and mid-operation reset.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run = 0;
  int tests_failed = 0;

  mdu_iter dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     sx, sy, q, r;
    logic [63:0] up;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      2'b01: begin
        up = {32'd0, x} * {32'd0, y};
        return up;
      end
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sx = x; sy = y;
        q = sx / sy; r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one op, scramble operands after E0, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int busy_n, output int done_at);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
    busy_n = 0; done_at = -1; rh = 32'hx; rl = 32'hx;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_at = k; rh = hi; rl = lo;
      end
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] rh, rl, prev_lo, ra, rb;
  logic [63:0] expv;
  logic [1:0]  ro;
  int          busy_n, done_at, done_cnt, first_done;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // directed vector table
    vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,          32'h0000_0001, 32'h7FFF_FFFC});
    vecs.push_back('{2'b11, 32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{2'b00, 32'd5,         32'd6,          32'h0000_0000, 32'h0000_001E});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, rh, rl, busy_n, done_at);
      check($sformatf("vec%0d_hilo", i), {rh, rl}, {vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("vec%0d_done_at", i), 64'(done_at), 64'd33);
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd33);
      if (i == 0) begin
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
      end
    end

    // randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      run_op(ro, ra, rb, rh, rl, busy_n, done_at);
      check($sformatf("rand%0d_op%0d_%h_%h", n, ro, ra, rb), {rh, rl}, model(ro, ra, rb));
      check($sformatf("rand%0d_done_at", n), 64'(done_at), 64'd33);
    end

    // start together with wr_lo in IDLE: start wins, write dropped
    @(negedge clk);
    prev_lo = lo;
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd11; wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("start_wr_lo_dropped", 64'(lo), 64'(prev_lo));
    done_at = -1;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (done) done_at = k;
    end
    check("start_wr_lo_done_at", 64'(done_at), 64'd33);
    check("start_wr_lo_result", {hi, lo}, 64'd99);

    // wr_lo and a second start pulsed while busy are both ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h0001_2345; b = 32'hFFFF_6789;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; first_done = -1; rh = 32'hx; rl = 32'hx;
    for (int k = 0; k < 76; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) begin
        start = 1'b1; op = 2'b11; a = $urandom; b = $urandom;
        wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (k == 5) begin
        start = 1'b0; wr_lo = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (first_done < 0) begin
          first_done = k; rh = hi; rl = lo;
        end
      end
    end
    check("busy_poke_done_count", 64'(done_cnt), 64'd1);
    check("busy_poke_done_at", 64'(first_done), 64'd33);
    check("busy_poke_result", {rh, rl}, model(2'b00, 32'h0001_2345, 32'hFFFF_6789));

    // idle mthi, then mthi+mtlo together
    @(negedge clk);
    prev_lo = lo;
    wr_hi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_lo_kept", 64'(lo), 64'(prev_lo));
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});

    // reset asserted at E10 of a running mult aborts it
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
